csa_nibble_sequencer: RTL and testbench



---
 rtl/csa_nibble_sequencer.sv | 126 ++++++++++++
 tb/tb_csa_nibble_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: streams operands one nibble per cycle through a
// shared 4-bit carry-select adder, with valid/ready handshakes on both sides.

module carrySellectAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;
  logic [2:0] hi;

  // Upper pair is precomputed for both carry values and picked by the lower carry.
  assign lo   = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
  assign hi0  = {1'b0, a[3:2]} + {1'b0, b[3:2]};
  assign hi1  = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
  assign hi   = lo[2] ? hi1 : hi0;
  assign sum  = {hi[1:0], lo[1:0]};
  assign cout = hi[2];
endmodule

module csa_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
      $error("csa_nibble_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  carrySellectAdder u_csa (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Each new nibble enters at the top, so after NIB shifts nibble 0 sits at the bottom.
  generate
    if (NIB == 1) begin : g_one_nibble
      assign sum_next = nib_sum;
    end else begin : g_multi_nibble
      assign sum_next = {nib_sum, sum_sh[WIDTH-1:4]};
    end
  endgenerate

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the datapath registers are reset too so an
  // aborted transaction leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          carry  <= nib_cout;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(NIB - 1)) begin
            sum   <= sum_next;
            cout  <= nib_cout;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_nibble_sequencer.sv
// Directed bench for csa_nibble_sequencer (WIDTH=16) with a result scoreboard queue.

module tb_csa_nibble_sequencer;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             cin_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic [WIDTH:0] exp_q[$];

  csa_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .cin       (cin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  task automatic do_accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    int n;
    a_in = x; b_in = y; cin_in = c; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    tick();
    acc_cyc = cyc;
    in_valid = 1'b0;
    exp_q.push_back(model(x, y, c));
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic collect(input string tag, input bit handshake);
    int n;
    logic [WIDTH:0] e;
    n = 0;
    while (!out_valid && n < 20) begin
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(NIB));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
      check({tag, "_cout"}, 32'(cout), 32'(e[WIDTH]));
    end
    if (handshake) begin
      out_ready = 1'b1;
      tick();
      check({tag, "_valid_fall"}, 32'(out_valid), 32'd0);
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    // Reset held with in_valid asserted.
    in_valid = 1'b1;
    a_in = 16'h5A5A;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Basic and full-ripple cases.
    out_ready = 1'b1;
    do_accept(16'h1234, 16'h4321, 1'b0);
    collect("basic", 1'b1);
    do_accept(16'hFFFF, 16'h0000, 1'b1);
    collect("ripple_cin", 1'b1);
    do_accept(16'h8000, 16'h8000, 1'b0);
    collect("ripple_msb", 1'b1);

    // Backpressure: result must hold while new operands are ignored.
    out_ready = 1'b0;
    do_accept(16'h00FF, 16'h0001, 1'b0);
    collect("bp", 1'b0);
    a_in = 16'hAAAA; b_in = 16'h1111; cin_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h0100);
      check("bp_hold_cout", 32'(cout), 32'd0);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_sum_kept", 32'(sum), 32'h0100);
    tick();
    acc_cyc = cyc;
    in_valid = 1'b0;
    exp_q.push_back(model(16'hAAAA, 16'h1111, 1'b1));
    check("bp_accept_busy", 32'(busy), 32'd1);
    collect("bp_next", 1'b1);

    // Reset in the middle of RUN.
    do_accept(16'hFFFF, 16'h0001, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst_release_ready", 32'(in_ready), 32'd1);
    do_accept(16'h0001, 16'h0001, 1'b0);
    collect("after_rst", 1'b1);

    // Back-to-back stream with out_ready held high.
    begin
      int issued, recv, last_out;
      bit accept_now;
      issued = 0; recv = 0; last_out = 0;
      out_ready = 1'b1;
      a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin_in = 1'($urandom);
      in_valid = 1'b1;
      for (int n = 0; n < 120 && recv < 8; n++) begin
        if (out_valid) begin
          logic [WIDTH:0] e;
          if (exp_q.size() == 0) begin
            check("b2b_scoreboard_empty", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("b2b_sum", 32'(sum), 32'(e[WIDTH-1:0]));
            check("b2b_cout", 32'(cout), 32'(e[WIDTH]));
          end
          if (recv > 0) check("b2b_spacing", 32'(cyc - last_out), 32'(NIB + 2));
          last_out = cyc;
          recv++;
        end
        accept_now = in_ready && in_valid;
        if (accept_now) exp_q.push_back(model(a_in, b_in, cin_in));
        tick();
        if (accept_now) begin
          issued++;
          a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin_in = 1'($urandom);
          if (issued == 8) in_valid = 1'b0;
        end
      end
      check("b2b_issued", 32'(issued), 32'd8);
      check("b2b_received", 32'(recv), 32'd8);
      check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
